// File: rtl/canny_frame_ctrl.sv
// canny_frame_ctrl: one-frame capture sequencer in front of the Canny detector.
// Define CANNY_CTRL_STATS_EN to build the saturating edge-pixel counter.
module canny_frame_ctrl #(
    parameter int WIDTH         = 8,
    parameter int H_RES         = 176,
    parameter int V_RES         = 144,
    parameter int H_BLANK       = 16,
    parameter int FLUSH_LINES   = 3,
    parameter int OUT_SKIP      = 0,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int ADDR_W        = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_vsync,
    input  logic              i_hsync,
    input  logic              i_de,
    input  logic [WIDTH-1:0]  i_data,
    output logic              o_ce_vsync,
    output logic              o_ce_hsync,
    output logic              o_ce_de,
    output logic [WIDTH-1:0]  o_ce_data,
    input  logic              i_ce_de,
    input  logic [WIDTH-1:0]  i_ce_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [WIDTH-1:0]  o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_err,
    output logic [ADDR_W-1:0] o_edge_cnt
);

    localparam logic [ADDR_W:0] NPIX  = (ADDR_W+1)'(H_RES*V_RES);
    localparam logic [ADDR_W:0] NLAST = (ADDR_W+1)'(H_RES*V_RES-1);
    localparam logic [15:0]     HRES  = 16'(H_RES);
    localparam logic [15:0]     LLAST = 16'(H_RES+H_BLANK-1);
    localparam logic [7:0]      FLAST = 8'(FLUSH_LINES-1);
    localparam logic [15:0]     SKIP  = 16'(OUT_SKIP);
    localparam logic [15:0]     TMO   = 16'(DRAIN_TIMEOUT-1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VS, S_STREAM, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               vs_q;
    logic               ce_vs_q, ce_vs_d;
    logic               ce_hs_q, ce_hs_d;
    logic               ce_de_q, ce_de_d;
    logic [WIDTH-1:0]   ce_data_q, ce_data_d;
    logic [1:0]         err_q, err_d;
    logic [ADDR_W:0]    in_cnt_q;
    logic [ADDR_W:0]    wr_cnt_q;
    logic [15:0]        fl_pos_q;
    logic [7:0]         fl_line_q;
    logic [15:0]        skip_q;
    logic [15:0]        drn_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [WIDTH-1:0]   wr_data_q;

    logic vs_rise, start_ok, last_px, fl_last;
    logic write_act, wr_fire;

    assign vs_rise   = i_vsync & ~vs_q;
    assign start_ok  = (state_q == S_IDLE) & i_start & ~i_abort;
    assign last_px   = i_de & (in_cnt_q == NLAST);
    assign fl_last   = (fl_pos_q == LLAST) & (fl_line_q == FLAST);
    assign write_act = (state_q == S_STREAM) | (state_q == S_FLUSH)
                     | (state_q == S_DRAIN);
    // Writes stop at the last address; late detector output is dropped.
    assign wr_fire   = write_act & i_ce_de & ~i_abort
                     & (skip_q == SKIP) & (wr_cnt_q != NPIX);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        ce_vs_d   = 1'b0;
        ce_hs_d   = 1'b0;
        ce_de_d   = 1'b0;
        ce_data_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_WAIT_VS;
                    err_d   = 2'b00;
                end
            end
            S_WAIT_VS: begin
                if (vs_rise) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (last_px || !vs_rise) begin
                    ce_vs_d   = i_vsync;
                    ce_hs_d   = i_hsync;
                    ce_de_d   = i_de;
                    ce_data_d = i_data;
                end
                if (last_px) begin
                    state_d = S_FLUSH;
                end else if (vs_rise) begin
                    err_d[0] = 1'b1;
                    state_d  = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fl_pos_q < HRES) ce_de_d = 1'b1;
                else                 ce_hs_d = 1'b1;
                if (fl_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (wr_cnt_q == NPIX) begin
                    state_d = S_DONE;
                end else if (drn_q == TMO) begin
                    err_d[1] = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            ce_vs_d   = 1'b0;
            ce_hs_d   = 1'b0;
            ce_de_d   = 1'b0;
            ce_data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            vs_q      <= 1'b0;
            err_q     <= 2'b00;
            ce_vs_q   <= 1'b0;
            ce_hs_q   <= 1'b0;
            ce_de_q   <= 1'b0;
            ce_data_q <= '0;
        end else begin
            state_q   <= state_d;
            vs_q      <= i_vsync;
            err_q     <= err_d;
            ce_vs_q   <= ce_vs_d;
            ce_hs_q   <= ce_hs_d;
            ce_de_q   <= ce_de_d;
            ce_data_q <= ce_data_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            fl_pos_q  <= '0;
            fl_line_q <= '0;
            skip_q    <= '0;
            drn_q     <= '0;
        end else if (start_ok) begin
            in_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            fl_pos_q  <= '0;
            fl_line_q <= '0;
            skip_q    <= '0;
            drn_q     <= '0;
        end else begin
            if (state_q == S_STREAM && i_de) in_cnt_q <= in_cnt_q + 1'b1;
            if (state_q == S_FLUSH) begin
                if (fl_pos_q == LLAST) begin
                    fl_pos_q  <= '0;
                    fl_line_q <= fl_line_q + 1'b1;
                end else begin
                    fl_pos_q  <= fl_pos_q + 1'b1;
                end
            end
            if (state_q == S_DRAIN) drn_q <= drn_q + 1'b1;
            if (write_act && i_ce_de && skip_q != SKIP) skip_q <= skip_q + 1'b1;
            if (wr_fire) wr_cnt_q <= wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= wr_fire;
            if (wr_fire) begin
                wr_addr_q <= wr_cnt_q[ADDR_W-1:0];
                wr_data_q <= i_ce_data;
            end
        end
    end

`ifdef CANNY_CTRL_STATS_EN
    logic [ADDR_W-1:0] edge_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_q <= '0;
        end else if (start_ok) begin
            edge_q <= '0;
        end else if (wr_fire && i_ce_data == {WIDTH{1'b1}} && edge_q != '1) begin
            edge_q <= edge_q + 1'b1;
        end
    end

    assign o_edge_cnt = edge_q;
`else
    assign o_edge_cnt = '0;
`endif

    assign o_ce_vsync = ce_vs_q;
    assign o_ce_hsync = ce_hs_q;
    assign o_ce_de    = ce_de_q;
    assign o_ce_data  = ce_data_q;
    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE);
    assign o_err      = err_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// tb_canny_frame_ctrl: directed bench for canny_frame_ctrl with a delay-line
// loopback standing in for the detector (reduced frame size for run time).
module tb_canny_frame_ctrl;

    localparam int W   = 8;
    localparam int H   = 32;
    localparam int V   = 24;
    localparam int HB  = 4;
    localparam int FL  = 3;
    localparam int TMO = 256;
    localparam int AW  = 15;
    localparam int D   = 2*H+10;
    localparam int SB  = 8;
    localparam int NP  = H*V;
`ifdef CANNY_CTRL_STATS_EN
    localparam int EDGE_EXP = 500;
`else
    localparam int EDGE_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_start, i_abort;
    logic          i_vsync, i_hsync, i_de;
    logic [W-1:0]  i_data;
    logic          o_ce_vsync, o_ce_hsync, o_ce_de;
    logic [W-1:0]  o_ce_data;
    logic          i_ce_de;
    logic [W-1:0]  i_ce_data;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [W-1:0]  o_wr_data;
    logic          o_busy, o_done;
    logic [1:0]    o_err;
    logic [AW-1:0] o_edge_cnt;

    int checks = 0;
    int failures = 0;
    int n_wr, bad_wr, n_de, n_hs, n_vs, n_done;
    int ff_n, data_lim;

    always #5 clk = ~clk;

    canny_frame_ctrl #(
        .WIDTH(W), .H_RES(H), .V_RES(V), .H_BLANK(HB),
        .FLUSH_LINES(FL), .OUT_SKIP(0), .DRAIN_TIMEOUT(TMO), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_start(i_start), .i_abort(i_abort),
        .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de), .i_data(i_data),
        .o_ce_vsync(o_ce_vsync), .o_ce_hsync(o_ce_hsync),
        .o_ce_de(o_ce_de), .o_ce_data(o_ce_data),
        .i_ce_de(i_ce_de), .i_ce_data(i_ce_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_edge_cnt(o_edge_cnt)
    );

    logic [W:0] dly_q [D];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < D; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= {o_ce_de, o_ce_data};
            for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign i_ce_de   = dly_q[D-1][W];
    assign i_ce_data = dly_q[D-1][W-1:0];

    function automatic logic [7:0] pix(int p);
        if (p < ff_n) return 8'hFF;
        return 8'(p & 127);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (o_wr_en) begin
            e = (int'(o_wr_addr) < data_lim) ? pix(int'(o_wr_addr)) : 8'h00;
            if (int'(o_wr_addr) != n_wr || o_wr_data !== e) bad_wr++;
            n_wr++;
        end
        if (o_ce_de)    n_de++;
        if (o_ce_hsync) n_hs++;
        if (o_ce_vsync) n_vs++;
        if (o_done)     n_done++;
    endtask

    task automatic clr();
        n_wr = 0; bad_wr = 0; n_de = 0;
        n_hs = 0; n_vs = 0; n_done = 0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_frame(int lines, int abort_at);
        i_vsync = 1'b1;
        tick();
        tick();
        i_vsync = 1'b0;
        repeat (4) tick();
        for (int l = 0; l < lines; l++) begin
            for (int x = 0; x < H; x++) begin
                i_de    = 1'b1;
                i_data  = pix(l*H + x);
                i_abort = (l*H + x == abort_at);
                tick();
                if (i_abort) begin
                    i_abort = 1'b0;
                    i_de    = 1'b0;
                    i_data  = '0;
                    return;
                end
            end
            i_de    = 1'b0;
            i_data  = '0;
            i_hsync = 1'b1;
            repeat (SB) tick();
            i_hsync = 1'b0;
        end
    endtask

    task automatic wait_done(int budget);
        for (int k = 0; k < budget && n_done == 0; k++) tick();
        chk("done_seen", n_done, 1);
    endtask

    initial begin
        rstn = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_vsync = 1'b0; i_hsync = 1'b0; i_de = 1'b0; i_data = '0;
        ff_n = 0; data_lim = NP;
        clr();
        repeat (3) tick();
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_outs", int'({o_done, o_err, o_wr_en, o_ce_de,
                              o_ce_hsync, o_ce_vsync}), 0);
        rstn = 1'b1;
        repeat (5) tick();
        chk("idle_busy", int'(o_busy), 0);
        chk("idle_ce_data", int'(o_ce_data), 0);
        chk("idle_wr", int'({o_wr_en, o_wr_addr, o_wr_data}), 0);
        chk("idle_edge", int'(o_edge_cnt), 0);

        // full frame, 500 leading 0xFF pixels, extra start while busy
        clr();
        ff_n = 500; data_lim = NP;
        pulse_start();
        chk("t2_busy", int'(o_busy), 1);
        repeat (3) tick();
        pulse_start();
        send_frame(V, -1);
        wait_done(1000);
        pulse_start();
        chk("t6_start_on_done", int'(o_busy), 0);
        repeat (150) tick();
        chk("t2_done_cnt", n_done, 1);
        chk("t2_busy_end", int'(o_busy), 0);
        chk("t2_writes", n_wr, NP);
        chk("t2_bad_wr", bad_wr, 0);
        chk("t2_err", int'(o_err), 0);
        chk("t4_edge_cnt", int'(o_edge_cnt), EDGE_EXP);
        chk("t2_ce_de", n_de, NP + FL*H);
        chk("t2_ce_hs", n_hs, (V-1)*SB + FL*HB);
        chk("t2_ce_vs", n_vs, 1);

        // short frame cut by a new vsync edge, then drain timeout
        clr();
        ff_n = 0; data_lim = 6*H;
        pulse_start();
        chk("t3_edge_clr", int'(o_edge_cnt), 0);
        send_frame(6, -1);
        i_vsync = 1'b1;
        tick();
        tick();
        i_vsync = 1'b0;
        wait_done(1000);
        chk("t3_err", int'(o_err), 3);
        repeat (150) tick();
        chk("t3_err_hold", int'(o_err), 3);
        chk("t3_ce_de", n_de, 6*H + FL*H);
        chk("t3_ce_hs", n_hs, 6*SB + FL*HB);
        chk("t3_ce_vs", n_vs, 1);
        chk("t3_writes", n_wr, 6*H + FL*H);
        chk("t3_bad_wr", bad_wr, 0);
        chk("t3_done_cnt", n_done, 1);

        // abort mid-stream, then a clean frame
        clr();
        ff_n = 0; data_lim = NP;
        pulse_start();
        chk("t5_err_clr", int'(o_err), 0);
        send_frame(V, 3*H + 5);
        chk("t5_busy", int'(o_busy), 0);
        chk("t5_ce_de", int'(o_ce_de), 0);
        chk("t5_wr_en", int'(o_wr_en), 0);
        repeat (150) tick();
        chk("t5_no_done", n_done, 0);
        clr();
        pulse_start();
        send_frame(V, -1);
        wait_done(1000);
        repeat (150) tick();
        chk("t5_writes", n_wr, NP);
        chk("t5_bad_wr", bad_wr, 0);
        chk("t5_err", int'(o_err), 0);
        chk("t5_done_cnt", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
